// File: rtl/demux_8_stream_pkg.sv
// Shared widths, channel-select type and select decode for the 8-channel stream demux.
package demux_8_stream_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_CH     = 8;
    localparam int SEL_WIDTH  = 3;
    localparam int CNT_WIDTH  = 16;

    typedef logic [SEL_WIDTH-1:0] ch_sel_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t sel);
        logic [NUM_CH-1:0] one;
        one = 1;
        return one << sel;
    endfunction

endpackage

// File: rtl/demux_8_stream_slot.sv
// One-entry valid/ready holding register for a single output channel, plus its
// accepted-word counter.
module demux_slot
    import demux_8_stream_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int CW = CNT_WIDTH
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_data,
    input  logic          i_out_ready,
    input  logic          i_clr,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_count
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [CW-1:0] r_count;

    // i_wr_en is only raised when the slot is empty or being drained this cycle,
    // so a write always wins over the drain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Clear has priority over a same-cycle increment; the counter wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_wr_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_count = r_count;

endmodule

// File: rtl/demux_8_stream.sv
// Registered 1-to-8 stream demultiplexer: select decode, in_ready mux and counter
// readback around eight independent holding slots.
module demux_8_stream
    import demux_8_stream_pkg::NUM_CH, demux_8_stream_pkg::ch_sel_t, demux_8_stream_pkg::sel_onehot;
#(
    parameter int WIDTH     = demux_8_stream_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH = demux_8_stream_pkg::CNT_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  ch_sel_t                   in_select,
    input  logic [WIDTH-1:0]          in_data,
    output logic [NUM_CH-1:0]         out_valid,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    input  ch_sel_t                   cnt_select,
    output logic [CNT_WIDTH-1:0]      cnt_value,
    input  logic                      clr_counts
);

    logic [NUM_CH-1:0]    w_out_valid;
    logic [NUM_CH-1:0]    w_wr_en;
    logic [CNT_WIDTH-1:0] w_count [NUM_CH];
    logic                 w_in_ready;
    logic                 w_accept;

    // Ready looks only at the addressed slot, so a stalled channel never blocks others.
    // Gating with reset_n keeps the input side closed while the block is held in reset.
    assign w_in_ready = reset_n & (~w_out_valid[in_select] | out_ready[in_select]);
    assign w_accept   = in_valid & w_in_ready;
    assign w_wr_en    = w_accept ? sel_onehot(in_select) : '0;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .DW (WIDTH),
            .CW (CNT_WIDTH)
        ) u_slot (
            .clock       (clock),
            .reset_n     (reset_n),
            .i_wr_en     (w_wr_en[k]),
            .i_data      (in_data),
            .i_out_ready (out_ready[k]),
            .i_clr       (clr_counts),
            .o_valid     (w_out_valid[k]),
            .o_data      (out_data[k*WIDTH +: WIDTH]),
            .o_count     (w_count[k])
        );
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign cnt_value = w_count[cnt_select];

endmodule
